// File: rtl/sram_1rw_wmask_init_if.sv
// Access bus for sram_1rw_wmask_init.
//   master: drives csb0 (active-low select), web0 (active-low write),
//           wmask0 (per-lane write enable), addr0, din0
//   slave : drives dout0 (read data, held between reads), dout_valid
//           (one-cycle read strobe), init_done (array zeroed and ready)
// With SRAM_PARITY_EN defined the bus also carries par_inject (master) and
// par_err (slave, per-lane parity mismatch qualified by dout_valid).
interface sram_1rw_wmask_init_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int WRITE_SIZE = 8
);
  localparam int NUM_WMASKS = DATA_WIDTH / WRITE_SIZE;

  logic                  csb0;
  logic                  web0;
  logic [NUM_WMASKS-1:0] wmask0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] din0;
  logic [DATA_WIDTH-1:0] dout0;
  logic                  dout_valid;
  logic                  init_done;

`ifdef SRAM_PARITY_EN
  logic                  par_inject;
  logic [NUM_WMASKS-1:0] par_err;

  modport master (output csb0, web0, wmask0, addr0, din0, par_inject,
                  input  dout0, dout_valid, init_done, par_err);
  modport slave  (input  csb0, web0, wmask0, addr0, din0, par_inject,
                  output dout0, dout_valid, init_done, par_err);
`else
  modport master (output csb0, web0, wmask0, addr0, din0,
                  input  dout0, dout_valid, init_done);
  modport slave  (input  csb0, web0, wmask0, addr0, din0,
                  output dout0, dout_valid, init_done);
`endif
endinterface

// File: rtl/sram_1rw_wmask_init.sv
// Parametrised single-port (1RW) behavioural SRAM with per-lane write mask,
// synchronous active-high reset, post-reset zero sweep, pipelined reads with
// a dout_valid strobe and deterministic output hold.
// Ports:
//   clk  - clock, all state changes on posedge
//   rst  - synchronous active-high reset; restarts the zero sweep
//   bus  - sram_1rw_wmask_init_if.slave (csb0, web0, wmask0, addr0, din0,
//          dout0, dout_valid, init_done)
// Optional: define SRAM_PARITY_EN to store one even-parity bit per lane,
// add par_inject (invert stored parity of written lanes) and par_err
// (per-lane mismatch, valid with dout_valid) on the bus.
module sram_1rw_wmask_init #(
  parameter int DATA_WIDTH   = 128,
  parameter int ADDR_WIDTH   = 6,
  parameter int WRITE_SIZE   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sram_1rw_wmask_init_if.slave  bus
);
  localparam int NUM_WMASKS = DATA_WIDTH / WRITE_SIZE;
  localparam int RAM_DEPTH  = 1 << ADDR_WIDTH;

  if (DATA_WIDTH % WRITE_SIZE != 0) begin : g_bad_write_size
    $error("DATA_WIDTH must be a multiple of WRITE_SIZE");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_read_latency
    $error("READ_LATENCY must be in 1..4");
  end

  typedef enum logic {INIT, READY} state_e;

  state_e                               state, state_nxt;
  logic [ADDR_WIDTH-1:0]                init_addr;
  logic                                 init_wr, wr_acc, rd_acc;
  logic [READ_LATENCY-1:0]              vld_pipe;
  logic                                 dout_valid_q;
  logic [NUM_WMASKS-1:0][WRITE_SIZE-1:0] dout_q;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      init_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_addr <= init_addr + ADDR_WIDTH'(1);
    end
  end

  // Accesses are only honoured in READY and never in a reset cycle.
  always_comb begin
    state_nxt = state;
    init_wr   = 1'b0;
    wr_acc    = 1'b0;
    rd_acc    = 1'b0;
    case (state)
      INIT: begin
        init_wr = !rst;
        if (&init_addr) state_nxt = READY;
      end
      READY: begin
        wr_acc = !rst && !bus.csb0 && !bus.web0;
        rd_acc = !rst && !bus.csb0 &&  bus.web0;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Read-valid pipeline: stage s is set s+1 posedges after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe     <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      vld_pipe[0] <= rd_acc;
      for (int s = 1; s < READ_LATENCY; s++) vld_pipe[s] <= vld_pipe[s-1];
      dout_valid_q <= vld_pipe[READ_LATENCY-1];
    end
  end

`ifdef SRAM_PARITY_EN
  logic [NUM_WMASKS-1:0] perr_q;
  assign bus.par_err = perr_q;
`endif

  // ---------------- per-lane storage and read path ----------------
  for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_lane
    logic [WRITE_SIZE-1:0] mem      [RAM_DEPTH];
    logic [WRITE_SIZE-1:0] dat_pipe [READ_LATENCY];
    logic [WRITE_SIZE-1:0] wdat;
    logic [WRITE_SIZE-1:0] dout_l;
    logic                  lane_we;

    assign wdat    = bus.din0[g*WRITE_SIZE +: WRITE_SIZE];
    assign lane_we = wr_acc && bus.wmask0[g];

    always_ff @(posedge clk) begin
      if (init_wr)      mem[init_addr] <= '0;
      else if (lane_we) mem[bus.addr0] <= wdat;
    end

    // Data stages shift every cycle; only vld_pipe decides what reaches dout0,
    // so unqualified stage contents never escape.
    always_ff @(posedge clk) begin
      dat_pipe[0] <= mem[bus.addr0];
      for (int s = 1; s < READ_LATENCY; s++) dat_pipe[s] <= dat_pipe[s-1];
    end

    always_ff @(posedge clk) begin
      if (rst)                             dout_l <= '0;
      else if (vld_pipe[READ_LATENCY-1])   dout_l <= dat_pipe[READ_LATENCY-1];
    end
    assign dout_q[g] = dout_l;

`ifdef SRAM_PARITY_EN
    logic par_mem  [RAM_DEPTH];
    logic par_pipe [READ_LATENCY];
    logic perr_l;

    // Even parity: stored bit equals XOR of lane data unless injected.
    always_ff @(posedge clk) begin
      if (init_wr)      par_mem[init_addr] <= 1'b0;
      else if (lane_we) par_mem[bus.addr0] <= ^wdat ^ bus.par_inject;
    end

    always_ff @(posedge clk) begin
      par_pipe[0] <= par_mem[bus.addr0];
      for (int s = 1; s < READ_LATENCY; s++) par_pipe[s] <= par_pipe[s-1];
    end

    always_ff @(posedge clk) begin
      if (rst) perr_l <= 1'b0;
      else     perr_l <= vld_pipe[READ_LATENCY-1] &&
                         (^dat_pipe[READ_LATENCY-1] ^ par_pipe[READ_LATENCY-1]);
    end
    assign perr_q[g] = perr_l;
`endif
  end

  assign bus.dout0      = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.init_done  = (state == READY);
endmodule

// File: tb/tb_sram_1rw_wmask_init.sv
// Bench for sram_1rw_wmask_init: two instances (READ_LATENCY 1 and 3) get
// identical stimulus; a memory model supplies expected read data which is
// queued per instance with its due cycle and checked when dout_valid fires.
`timescale 1ns/1ps
module tb_sram_1rw_wmask_init;
  localparam int DW = 128, AW = 6, WS = 8, NW = DW / WS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sram_1rw_wmask_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_SIZE(WS)) bus1 ();
  sram_1rw_wmask_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_SIZE(WS)) bus3 ();

  sram_1rw_wmask_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_SIZE(WS), .READ_LATENCY(1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  sram_1rw_wmask_init #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WRITE_SIZE(WS), .READ_LATENCY(3))
    dut3 (.clk(clk), .rst(rst), .bus(bus3));

  typedef struct {
    logic [DW-1:0] d;
    logic [NW-1:0] p;
    int            due;
  } exp_t;

  exp_t          q1[$], q3[$];
  exp_t          e1, e3;
  logic [DW-1:0] model  [64];
  logic [NW-1:0] pmodel [64];
  int            n_chk = 0, n_err = 0;
  bit            rdy = 1'b0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drv(input logic csb, input logic web, input logic [NW-1:0] wm,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus1.csb0 = csb; bus1.web0 = web; bus1.wmask0 = wm; bus1.addr0 = a; bus1.din0 = d;
    bus3.csb0 = csb; bus3.web0 = web; bus3.wmask0 = wm; bus3.addr0 = a; bus3.din0 = d;
`ifdef SRAM_PARITY_EN
    bus1.par_inject = 1'b0; bus3.par_inject = 1'b0;
`endif
  endtask

  // Called just after a posedge; the access is taken at the next posedge.
  task automatic op(input logic csb, input logic web, input logic [NW-1:0] wm,
                    input logic [AW-1:0] a, input logic [DW-1:0] d, input logic inj);
    drv(csb, web, wm, a, d);
`ifdef SRAM_PARITY_EN
    bus1.par_inject = inj; bus3.par_inject = inj;
`endif
    if (rdy && !csb) begin
      if (!web) begin
        for (int i = 0; i < NW; i++)
          if (wm[i]) begin
            model[a][i*WS +: WS] = d[i*WS +: WS];
            pmodel[a][i]         = inj;
          end
      end else begin
        q1.push_back('{model[a], pmodel[a], cyc + 2});
        q3.push_back('{model[a], pmodel[a], cyc + 4});
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) op(1'b1, 1'b1, '0, '0, '0, 1'b0);
  endtask

  task automatic zero_model();
    for (int i = 0; i < 64; i++) begin
      model[i]  = '0;
      pmodel[i] = '0;
    end
  endtask

  // Entered just after the posedge where rst was seen high for the last time.
  // Drives a write and then a read during the sweep; both must be ignored.
  task automatic init_seq();
    drv(1'b0, 1'b0, '1, 6'd0, 128'h1);
    repeat (40) @(posedge clk);
    #1 drv(1'b0, 1'b1, '0, 6'd3, '0);
    repeat (23) @(posedge clk);
    @(negedge clk);
    chk("init_done_lo_l1", bus1.init_done, 1'b0);
    chk("init_done_lo_l3", bus3.init_done, 1'b0);
    @(posedge clk); #1 drv(1'b1, 1'b1, '0, '0, '0);
    @(negedge clk);
    chk("init_done_hi_l1", bus1.init_done, 1'b1);
    chk("init_done_hi_l3", bus3.init_done, 1'b1);
    @(posedge clk); #1;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].due == cyc) chk("l1_vld_due", bus1.dout_valid, 1'b1);
    if (bus1.dout_valid === 1'b1) begin
      if (q1.size() == 0) chk("l1_vld_spurious", bus1.dout_valid, 1'b0);
      else begin
        e1 = q1.pop_front();
        chk("l1_dout", bus1.dout0, e1.d);
        chk("l1_vld_cycle", cyc, e1.due);
`ifdef SRAM_PARITY_EN
        chk("l1_par_err", bus1.par_err, e1.p);
`endif
      end
    end
`ifdef SRAM_PARITY_EN
    else chk("l1_par_err_idle", bus1.par_err, '0);
`endif
  end

  always @(negedge clk) begin
    if (q3.size() > 0 && q3[0].due == cyc) chk("l3_vld_due", bus3.dout_valid, 1'b1);
    if (bus3.dout_valid === 1'b1) begin
      if (q3.size() == 0) chk("l3_vld_spurious", bus3.dout_valid, 1'b0);
      else begin
        e3 = q3.pop_front();
        chk("l3_dout", bus3.dout0, e3.d);
        chk("l3_vld_cycle", cyc, e3.due);
`ifdef SRAM_PARITY_EN
        chk("l3_par_err", bus3.par_err, e3.p);
`endif
      end
    end
`ifdef SRAM_PARITY_EN
    else chk("l3_par_err_idle", bus3.par_err, '0);
`endif
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [DW-1:0] pat, rdat;
  logic [DW-1:0] va = 128'hA5A5_0123_4567_89AB_CDEF_0F1E_2D3C_4B5A;
  logic [DW-1:0] vb = 128'h5A5A_FEDC_BA98_7654_3210_F0E1_D2C3_B4A5;
  int            r;

  initial begin
    drv(1'b1, 1'b1, '0, '0, '0);
    zero_model();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout_l1", bus1.dout0, '0);
    chk("rst_vld_l1",  bus1.dout_valid, 1'b0);
    chk("rst_done_l1", bus1.init_done, 1'b0);
    chk("rst_dout_l3", bus3.dout0, '0);
    chk("rst_vld_l3",  bus3.dout_valid, 1'b0);
    chk("rst_done_l3", bus3.init_done, 1'b0);
    rst = 1'b0;
    init_seq();
    rdy = 1'b1;

    // Zeroed array; write to addr 0 during the sweep must not have landed.
    op(1'b0, 1'b1, '0, 6'd63, '0, 1'b0);
    op(1'b0, 1'b1, '0, 6'd0,  '0, 1'b0);

    // Masked write of the descending byte pattern, low 8 lanes only.
    for (int i = 0; i < NW; i++) pat[i*WS +: WS] = 8'(255 - 17 * i);
    op(1'b0, 1'b0, 16'h00FF, 6'd5, pat, 1'b0);
    op(1'b0, 1'b1, '0, 6'd5, '0, 1'b0);
    idle(4);

    // Back-to-back pipelined reads, then output hold.
    op(1'b0, 1'b0, '1, 6'd1, va, 1'b0);
    op(1'b0, 1'b0, '1, 6'd2, vb, 1'b0);
    op(1'b0, 1'b1, '0, 6'd1, '0, 1'b0);
    op(1'b0, 1'b1, '0, 6'd2, '0, 1'b0);
    op(1'b0, 1'b1, '0, 6'd1, '0, 1'b0);
    idle(6);
    chk("hold_l1", bus1.dout0, va);
    chk("hold_l3", bus3.dout0, va);

    // Write then read the same word on the next cycle.
    op(1'b0, 1'b0, '1, 6'd9, ~va, 1'b0);
    op(1'b0, 1'b1, '0, 6'd9, '0, 1'b0);
    // All-zero mask is a no-op; wmask0 on a read is ignored.
    op(1'b0, 1'b0, '0, 6'd5, '1, 1'b0);
    op(1'b0, 1'b0, 16'hFFFF, 6'd5, '0, 1'b0);
    op(1'b0, 1'b1, 16'hFFFF, 6'd5, '0, 1'b0);

    // Parity inject on two lanes, then a clean rewrite.
    op(1'b0, 1'b0, 16'h0003, 6'd7, vb, 1'b1);
    op(1'b0, 1'b1, '0, 6'd7, '0, 1'b0);
    op(1'b0, 1'b0, '1, 6'd7, va, 1'b0);
    op(1'b0, 1'b1, '0, 6'd7, '0, 1'b0);
    idle(4);

    // Mixed random traffic over a small address window.
    repeat (60) begin
      r    = $urandom_range(0, 3);
      rdat = {$urandom(), $urandom(), $urandom(), $urandom()};
      case (r)
        0: idle(1);
        1: op(1'b0, 1'b0, NW'($urandom()), AW'($urandom_range(0, 15)), rdat,
              1'($urandom_range(0, 1)));
        default: op(1'b0, 1'b1, NW'($urandom()), AW'($urandom_range(0, 15)), '0, 1'b0);
      endcase
    end
    op(1'b0, 1'b0, '1, 6'd5, vb, 1'b0);
    op(1'b0, 1'b1, '0, 6'd5, '0, 1'b0);
    idle(6);

    // Reset right after a read is accepted: the read is dropped.
    op(1'b0, 1'b1, '0, 6'd5, '0, 1'b0);
    rst = 1'b1;
    drv(1'b1, 1'b1, '0, '0, '0);
    q1.delete();
    q3.delete();
    @(posedge clk); #1;
    chk("midrst_dout_l1", bus1.dout0, '0);
    chk("midrst_vld_l1",  bus1.dout_valid, 1'b0);
    chk("midrst_done_l1", bus1.init_done, 1'b0);
    chk("midrst_dout_l3", bus3.dout0, '0);
    chk("midrst_vld_l3",  bus3.dout_valid, 1'b0);
    chk("midrst_done_l3", bus3.init_done, 1'b0);
    rst = 1'b0;
    rdy = 1'b0;
    zero_model();
    init_seq();
    rdy = 1'b1;
    op(1'b0, 1'b1, '0, 6'd5, '0, 1'b0);
    op(1'b0, 1'b1, '0, 6'd1, '0, 1'b0);
    idle(6);

    chk("q1_drained", DW'(q1.size()), '0);
    chk("q3_drained", DW'(q3.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
